// File: rtl/spi_byte_rx_pkg.sv
// Shared types and default sizes for the SPI slave byte assembler.
package spi_byte_rx_pkg;

    localparam int BYTE_WIDTH_DEF = 8;
    localparam int IDX_WIDTH_DEF  = 16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/spi_byte_rx.sv
// SPI slave byte assembler: shifts MOSI MSB-first on SCLK rising enables, strobes whole bytes with in-frame index.
// Strobes are registered (one cycle after the sampling clock); no backpressure, consumer must take every strobe.
module spi_byte_rx
    import spi_byte_rx_pkg::*;
#(
    parameter int BYTE_WIDTH = BYTE_WIDTH_DEF,
    parameter int IDX_WIDTH  = IDX_WIDTH_DEF
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  sclk_rising_in,
    input  logic                  cs_n_rising_in,
    input  logic                  cs_n_falling_in,
    input  logic                  mosi_in,
    output logic [BYTE_WIDTH-1:0] byte_data_out,
    output logic                  byte_valid_out,
    output logic [IDX_WIDTH-1:0]  byte_idx_out,
    output logic                  frame_done_out,
    output logic                  frame_err_out
);

    localparam int                   BCW      = $clog2(BYTE_WIDTH);
    localparam logic [BCW-1:0]       LAST_BIT = BCW'(BYTE_WIDTH - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_MAX  = '1;

    state_e                state;
    logic [BCW-1:0]        bit_cnt;
    // Only the low BYTE_WIDTH-1 bits are ever needed: the final bit goes straight from mosi_in to the output.
    logic [BYTE_WIDTH-2:0] shift_reg;
    logic [IDX_WIDTH-1:0]  byte_cnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= ST_IDLE;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            byte_cnt       <= '0;
            byte_data_out  <= '0;
            byte_idx_out   <= '0;
            byte_valid_out <= 1'b0;
            frame_done_out <= 1'b0;
            frame_err_out  <= 1'b0;
        end else begin
            byte_valid_out <= 1'b0;
            frame_done_out <= 1'b0;
            frame_err_out  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Both CS enables together count as frame end, which is a no-op when idle.
                    if (cs_n_falling_in && !cs_n_rising_in) begin
                        state     <= ST_SHIFT;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                        byte_cnt  <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (cs_n_rising_in) begin
                        state          <= ST_IDLE;
                        frame_done_out <= 1'b1;
                        frame_err_out  <= (bit_cnt != '0);
                        bit_cnt        <= '0;
                    end else if (cs_n_falling_in) begin
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                        byte_cnt  <= '0;
                    end else if (sclk_rising_in) begin
                        shift_reg <= {shift_reg[BYTE_WIDTH-3:0], mosi_in};
                        if (bit_cnt == LAST_BIT) begin
                            byte_data_out  <= {shift_reg, mosi_in};
                            byte_idx_out   <= byte_cnt;
                            byte_valid_out <= 1'b1;
                            bit_cnt        <= '0;
                            if (byte_cnt != IDX_MAX) begin
                                byte_cnt <= byte_cnt + IDX_WIDTH'(1);
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_byte_rx.sv
// Randomised and directed bench for spi_byte_rx against a queue-based frame model (16-bit and 2-bit index builds).
module tb_spi_byte_rx;

    logic        clk_in          = 1'b0;
    logic        rst_n_in        = 1'b0;
    logic        sclk_rising_in  = 1'b0;
    logic        cs_n_rising_in  = 1'b0;
    logic        cs_n_falling_in = 1'b0;
    logic        mosi_in         = 1'b0;

    logic [7:0]  data16, data2;
    logic [15:0] idx16;
    logic [1:0]  idx2;
    logic        valid16, valid2, done16, done2, err16, err2;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: bits of the current frame in a queue, bytes counted by plain integers.
    bit         in_frame;
    int         q[$];
    int         byte_n;
    logic [7:0] m_data;
    int         m_idx;
    bit         m_valid, m_done, m_err;

    always #5 clk_in = ~clk_in;

    spi_byte_rx #(.BYTE_WIDTH(8), .IDX_WIDTH(16)) dut16 (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .sclk_rising_in  (sclk_rising_in),
        .cs_n_rising_in  (cs_n_rising_in),
        .cs_n_falling_in (cs_n_falling_in),
        .mosi_in         (mosi_in),
        .byte_data_out   (data16),
        .byte_valid_out  (valid16),
        .byte_idx_out    (idx16),
        .frame_done_out  (done16),
        .frame_err_out   (err16)
    );

    spi_byte_rx #(.BYTE_WIDTH(8), .IDX_WIDTH(2)) dut2 (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .sclk_rising_in  (sclk_rising_in),
        .cs_n_rising_in  (cs_n_rising_in),
        .cs_n_falling_in (cs_n_falling_in),
        .mosi_in         (mosi_in),
        .byte_data_out   (data2),
        .byte_valid_out  (valid2),
        .byte_idx_out    (idx2),
        .frame_done_out  (done2),
        .frame_err_out   (err2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        in_frame = 0;
        q.delete();
        byte_n  = 0;
        m_data  = '0;
        m_idx   = 0;
        m_valid = 0;
        m_done  = 0;
        m_err   = 0;
    endtask

    task automatic model_step(input bit rise, input bit fall, input bit sclk, input bit mosi);
        int val;
        m_valid = 0;
        m_done  = 0;
        m_err   = 0;
        if (!in_frame) begin
            if (fall && !rise) begin
                in_frame = 1;
                q.delete();
                byte_n = 0;
            end
        end else if (rise) begin
            m_done   = 1;
            m_err    = (q.size() != 0);
            in_frame = 0;
            q.delete();
        end else if (fall) begin
            q.delete();
            byte_n = 0;
        end else if (sclk) begin
            q.push_back(int'(mosi));
            if (q.size() == 8) begin
                val = 0;
                foreach (q[i]) val = val * 2 + q[i];
                m_data  = val[7:0];
                m_idx   = byte_n;
                m_valid = 1;
                byte_n++;
                q.delete();
            end
        end
    endtask

    task automatic check_outputs();
        int e16, e2;
        e16 = (m_idx > 65535) ? 65535 : m_idx;
        e2  = (m_idx > 3) ? 3 : m_idx;
        check_eq("valid16", 32'(valid16), 32'(m_valid));
        check_eq("data16",  32'(data16),  32'(m_data));
        check_eq("idx16",   32'(idx16),   32'(e16));
        check_eq("done16",  32'(done16),  32'(m_done));
        check_eq("err16",   32'(err16),   32'(m_err));
        check_eq("valid2",  32'(valid2),  32'(m_valid));
        check_eq("data2",   32'(data2),   32'(m_data));
        check_eq("idx2",    32'(idx2),    32'(e2));
        check_eq("done2",   32'(done2),   32'(m_done));
        check_eq("err2",    32'(err2),    32'(m_err));
    endtask

    task automatic step(input bit rise, input bit fall, input bit sclk, input bit mosi);
        cs_n_rising_in  = rise;
        cs_n_falling_in = fall;
        sclk_rising_in  = sclk;
        mosi_in         = mosi;
        model_step(rise, fall, sclk, mosi);
        @(posedge clk_in);
        #1;
        check_outputs();
        cs_n_rising_in  = 1'b0;
        cs_n_falling_in = 1'b0;
        sclk_rising_in  = 1'b0;
        mosi_in         = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(0, 0, 1, v[i]);
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cs_n_rising_in  = 1'($urandom_range(0, 1));
            cs_n_falling_in = 1'($urandom_range(0, 1));
            sclk_rising_in  = 1'($urandom_range(0, 1));
            mosi_in         = 1'($urandom_range(0, 1));
            @(posedge clk_in);
            #1;
            check_outputs();
        end
        cs_n_rising_in  = 1'b0;
        cs_n_falling_in = 1'b0;
        sclk_rising_in  = 1'b0;
        mosi_in         = 1'b0;
    endtask

    initial begin
        logic [7:0] rb;
        int         r;
        int         len;

        model_reset();
        #1;
        reset_cycles(6);
        rst_n_in = 1'b1;

        // Two-byte frame.
        step(0, 1, 0, 0);
        send_byte(8'hA5);
        step(0, 0, 0, 0);
        send_byte(8'h3C);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        // 12 edges: one byte then a partial nibble.
        step(0, 1, 0, 0);
        send_byte(8'hFF);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
        step(1, 0, 0, 0);

        // Edges while idle are ignored, then a normal frame.
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        send_byte(8'h81);
        step(1, 0, 0, 0);

        // Seven bits, eighth edge coincident with frame end.
        step(0, 1, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 1);
        step(1, 0, 1, 1);
        // Edge coincident with frame start is dropped.
        step(0, 1, 1, 1);
        send_byte(8'h42);
        // Both CS enables together end the frame; restart glitch mid-byte.
        step(0, 0, 1, 1);
        step(0, 1, 0, 0);
        send_byte(8'h17);
        step(1, 1, 0, 0);

        // Six bytes: 2-bit index saturates at 3.
        step(0, 1, 0, 0);
        for (int b = 0; b < 6; b++) send_byte(8'(8'h10 + b));
        // Reset after three bits of the seventh byte.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
        #2;
        rst_n_in = 1'b0;
        model_reset();
        #1;
        check_outputs();
        reset_cycles(3);
        rst_n_in = 1'b1;
        for (int i = 0; i < 10; i++) step(0, 0, 1, 1);
        step(1, 0, 0, 0);

        // Random frames with restarts, coincident events and idle gaps.
        for (int f = 0; f < 40; f++) begin
            step(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            len = $urandom_range(0, 45);
            for (int c = 0; c < len; c++) begin
                r = $urandom_range(0, 99);
                if (r < 60)      step(0, 0, 1, 1'($urandom_range(0, 1)));
                else if (r < 63) step(0, 1, 0, 0);
                else if (r < 66) step(0, 1, 1, 1'($urandom_range(0, 1)));
                else             step(0, 0, 0, 0);
            end
            rb = 8'($urandom);
            step(1, rb[0], rb[1], rb[2]);
            for (int c = 0; c < int'(rb[5:3]); c++) step(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
